// File: rtl/mod_add_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : mod_add_arbiter (with helper mod_add)
// Purpose  : Round-robin arbiter sharing one modular adder among NB_REQ
//            requesters; one registered result per cycle with backpressure.
// Options  : define MOD_ADD_ARB_STATS_EN to add the op_cnt_o handshake counter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mod_add (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic [22:0] q,
  output logic [22:0] c
);
  logic [24:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  // Single conditional subtract; result truncated to the modulus width.
  assign c = (sum >= {2'b00, q}) ? 23'(sum - {2'b00, q}) : sum[22:0];
endmodule

module mod_add_arbiter #(
  parameter int NB_REQ = 4,
  parameter int ID_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [22:0]          q_i,
  input  logic [NB_REQ-1:0]    req_valid_i,
  input  logic [NB_REQ*24-1:0] req_a_i,
  input  logic [NB_REQ*24-1:0] req_b_i,
  output logic [NB_REQ-1:0]    req_ready_o,
  output logic                 res_valid_o,
  output logic [22:0]          res_c_o,
  output logic [ID_W-1:0]      res_id_o,
  input  logic                 res_ready_i
`ifdef MOD_ADD_ARB_STATS_EN
  ,
  output logic [15:0]          op_cnt_o
`endif
);

  logic [ID_W-1:0]   ptr;
  logic              can_accept;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [NB_REQ-1:0] grant_oh;
  logic [ID_W:0]     cand;
  logic [ID_W-1:0]   ptr_next;
  logic              xfer;
  logic [23:0]       sel_a;
  logic [23:0]       sel_b;
  logic [22:0]       sum_c;

  assign can_accept = !res_valid_o || res_ready_i;

  // Scan upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    if (can_accept) begin
      for (int i = 0; i < NB_REQ; i++) begin
        cand = {1'b0, ptr} + (ID_W+1)'(i);
        if (cand >= (ID_W+1)'(NB_REQ)) begin
          cand = cand - (ID_W+1)'(NB_REQ);
        end
        if (!grant_vld && req_valid_i[cand[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[ID_W-1:0];
        end
      end
      if (grant_vld) begin
        grant_oh[grant_idx] = 1'b1;
      end
    end
  end

  // Ready is suppressed while reset is held so nothing appears accepted.
  assign req_ready_o = rst_ni ? grant_oh : '0;
  assign xfer        = grant_vld && rst_ni;
  assign ptr_next    = (grant_idx == ID_W'(NB_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  assign sel_a = req_a_i[32'(grant_idx) * 32'd24 +: 24];
  assign sel_b = req_b_i[32'(grant_idx) * 32'd24 +: 24];

  mod_add u_mod_add (
    .a (sel_a),
    .b (sel_b),
    .q (q_i),
    .c (sum_c)
  );

  // Result register and round-robin pointer; stall holds everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      res_c_o     <= '0;
      res_id_o    <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      res_valid_o <= 1'b1;
      res_c_o     <= sum_c;
      res_id_o    <= grant_idx;
      ptr         <= ptr_next;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

`ifdef MOD_ADD_ARB_STATS_EN
  // Count completed output handshakes, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_o <= '0;
    end else if (res_valid_o && res_ready_i && (op_cnt_o != 16'hFFFF)) begin
      op_cnt_o <= op_cnt_o + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_add_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_mod_add_arbiter
// Purpose  : Directed self-checking bench for mod_add_arbiter (NB_REQ=4).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_add_arbiter;
  localparam int NB_REQ = 4;
  localparam int ID_W   = 2;
  localparam logic [22:0] Q = 23'd8380417;

  logic                 clk_i;
  logic                 rst_ni;
  logic [22:0]          q_i;
  logic [NB_REQ-1:0]    req_valid_i;
  logic [NB_REQ*24-1:0] req_a_i;
  logic [NB_REQ*24-1:0] req_b_i;
  logic [NB_REQ-1:0]    req_ready_o;
  logic                 res_valid_o;
  logic [22:0]          res_c_o;
  logic [ID_W-1:0]      res_id_o;
  logic                 res_ready_i;
`ifdef MOD_ADD_ARB_STATS_EN
  logic [15:0]          op_cnt_o;
`endif

  int vectors;
  int errors;

  mod_add_arbiter #(.NB_REQ(NB_REQ), .ID_W(ID_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .q_i         (q_i),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_ready_o (req_ready_o),
    .res_valid_o (res_valid_o),
    .res_c_o     (res_c_o),
    .res_id_o    (res_id_o),
    .res_ready_i (res_ready_i)
`ifdef MOD_ADD_ARB_STATS_EN
    ,
    .op_cnt_o    (op_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input int k, input logic [23:0] a, input logic [23:0] b);
    req_a_i[k*24 +: 24] = a;
    req_b_i[k*24 +: 24] = b;
  endtask

  task automatic apply_reset();
    req_valid_i = '0;
    res_ready_i = 1'b1;
    rst_ni      = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    vectors++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", res_valid_o);
    end
    vectors++;
    if (res_c_o !== 23'd0 || res_id_o !== 2'd0) begin
      errors++; $display("FAIL reset_data got c=%0d id=%0d exp c=0 id=0", res_c_o, res_id_o);
    end
    vectors++;
    if (req_ready_o !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b exp 0000", req_ready_o);
    end
  endtask

  task automatic test_basic();
    set_op(0, 24'd5, 24'd7);
    req_valid_i = 4'b0001;
    #1;
    vectors++;
    if (req_ready_o !== 4'b0001) begin
      errors++; $display("FAIL basic_ready got %b exp 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    vectors++;
    if (res_valid_o !== 1'b1 || res_c_o !== 23'd12 || res_id_o !== 2'd0) begin
      errors++; $display("FAIL basic_result got v=%0b c=%0d id=%0d exp v=1 c=12 id=0",
                         res_valid_o, res_c_o, res_id_o);
    end
    tick();
    vectors++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_drain got v=%0b exp 0", res_valid_o);
    end
  endtask

  // Pointer is 1 on entry; three single transfers from requester 2.
  task automatic test_wrap();
    logic [23:0] av [3];
    logic [23:0] bv [3];
    logic [22:0] ev [3];
    av = '{24'd8380416, 24'd8380416, 24'd8380416};
    bv = '{24'd1,       24'd8380416, 24'd0};
    ev = '{23'd0,       23'd8380415, 23'd8380416};
    for (int i = 0; i < 3; i++) begin
      set_op(2, av[i], bv[i]);
      req_valid_i = 4'b0100;
      #1;
      vectors++;
      if (req_ready_o !== 4'b0100) begin
        errors++; $display("FAIL wrap_ready[%0d] got %b exp 0100", i, req_ready_o);
      end
      tick();
      req_valid_i = '0;
      vectors++;
      if (res_valid_o !== 1'b1 || res_c_o !== ev[i] || res_id_o !== 2'd2) begin
        errors++; $display("FAIL wrap_result[%0d] got v=%0b c=%0d id=%0d exp v=1 c=%0d id=2",
                           i, res_valid_o, res_c_o, res_id_o, ev[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [22:0] ec [4];
    logic [1:0]  g;
    ec = '{23'd100, 23'd201, 23'd302, 23'd403};
    apply_reset();
    for (int k = 0; k < 4; k++) set_op(k, 24'(100 * (k + 1)), 24'(k));
    req_valid_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      g = 2'(i % 4);
      #1;
      vectors++;
      if (req_ready_o !== (4'b0001 << g)) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_ready_o, 4'b0001 << g);
      end
      tick();
      vectors++;
      if (res_valid_o !== 1'b1 || res_id_o !== g || res_c_o !== ec[g]) begin
        errors++; $display("FAIL rr_result[%0d] got v=%0b c=%0d id=%0d exp v=1 c=%0d id=%0d",
                           i, res_valid_o, res_c_o, res_id_o, ec[g], g);
      end
    end
    req_valid_i = '0;
    tick();
    vectors++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL rr_drain got v=%0b exp 0", res_valid_o);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_op(1, 24'd1, 24'd2);
    set_op(0, 24'd10, 24'd1);
    set_op(3, 24'd20, 24'd2);
    req_valid_i = 4'b0010;
    tick();
    res_ready_i = 1'b0;
    req_valid_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (req_ready_o !== 4'b0000 || res_valid_o !== 1'b1 || res_c_o !== 23'd3 || res_id_o !== 2'd1) begin
        errors++; $display("FAIL stall_hold[%0d] got rdy=%b v=%0b c=%0d id=%0d exp rdy=0000 v=1 c=3 id=1",
                           i, req_ready_o, res_valid_o, res_c_o, res_id_o);
      end
      tick();
    end
    res_ready_i = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 4'b1000) begin
      errors++; $display("FAIL stall_release_grant got %b exp 1000", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    vectors++;
    if (res_valid_o !== 1'b1 || res_c_o !== 23'd22 || res_id_o !== 2'd3) begin
      errors++; $display("FAIL stall_release_result got v=%0b c=%0d id=%0d exp v=1 c=22 id=3",
                         res_valid_o, res_c_o, res_id_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) set_op(k, 24'(k + 1), 24'd1);
    req_valid_i = 4'b1111;
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (res_valid_o !== 1'b0 || req_ready_o !== 4'b0000 || res_c_o !== 23'd0 || res_id_o !== 2'd0) begin
      errors++; $display("FAIL async_reset got v=%0b rdy=%b c=%0d id=%0d exp v=0 rdy=0000 c=0 id=0",
                         res_valid_o, req_ready_o, res_c_o, res_id_o);
    end
    req_valid_i = 4'b0011;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 4'b0001) begin
      errors++; $display("FAIL post_reset_grant got %b exp 0001", req_ready_o);
    end
    tick();
    vectors++;
    if (res_valid_o !== 1'b1 || res_id_o !== 2'd0 || res_c_o !== 23'd2 || req_ready_o !== 4'b0010) begin
      errors++; $display("FAIL post_reset_result got v=%0b id=%0d c=%0d rdy=%b exp v=1 id=0 c=2 rdy=0010",
                         res_valid_o, res_id_o, res_c_o, req_ready_o);
    end
    req_valid_i = '0;
    tick();
    tick();
  endtask

`ifdef MOD_ADD_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    vectors++;
    if (op_cnt_o !== 16'd0) begin
      errors++; $display("FAIL stats_reset got %0d exp 0", op_cnt_o);
    end
    set_op(0, 24'd1, 24'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 4'b0001;
      tick();
      req_valid_i = '0;
      tick();
    end
    vectors++;
    if (op_cnt_o !== 16'd5) begin
      errors++; $display("FAIL stats_count got %0d exp 5", op_cnt_o);
    end
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    res_ready_i = 1'b0;
    tick();
    tick();
    vectors++;
    if (op_cnt_o !== 16'd5) begin
      errors++; $display("FAIL stats_stall got %0d exp 5", op_cnt_o);
    end
    res_ready_i = 1'b1;
    tick();
    vectors++;
    if (op_cnt_o !== 16'd6) begin
      errors++; $display("FAIL stats_after_stall got %0d exp 6", op_cnt_o);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    errors      = 0;
    q_i         = Q;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    res_ready_i = 1'b1;
    rst_ni      = 1'b1;
    #2;
    rst_ni      = 1'b0;
    #1;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_async_reset();
`ifdef MOD_ADD_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_add_arbiter.md
Name: mod_add_arbiter

Overview:
Round-robin arbiter that shares one modular adder among NB_REQ requesters inside the PE. Each requester presents an operand pair with a valid/ready handshake. The winner's operands go through one instance of mod_add, and the 23-bit result is registered together with the requester ID. One result per cycle is sustained, and output backpressure is supported.

Parameters:
NB_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(NB_REQ)

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_ni  in  1  asynchronous active-low reset
q_i  in  23  modulus, shared by all requesters, quasi-static
req_valid_i  in  NB_REQ  per-requester request valid
req_a_i  in  NB_REQ*24  packed operand a; requester k uses bits [24k+23:24k]
req_b_i  in  NB_REQ*24  packed operand b, same packing as req_a_i
req_ready_o  out  NB_REQ  per-requester accept, one-hot or zero
res_valid_o  out  1  result register holds valid data
res_c_o  out  23  (a+b) mod q of the accepted pair
res_id_o  out  ID_W  index of the requester that produced res_c_o
res_ready_i  in  1  downstream accepts the result

Behaviour:
- Reset values: res_valid_o=0, res_c_o=0, res_id_o=0, req_ready_o=0. Round-robin pointer=0, so requester 0 has highest priority first.
- Arithmetic: a single mod_add instance computes c = (a+b >= q) ? a+b-q : a+b, truncated to 23 bits.
- Operand contract: a<q, b<q, q<2^23, so a+b fits in 24 bits. Out-of-contract operands give an undefined result value. The handshake must stay correct regardless.
- Stage free: can_accept = !res_valid_o || res_ready_i.
- Grant, combinational:
  - When can_accept=1, grant goes to the first set req_valid_i bit, scanning upward (with wrap) from the pointer.
  - req_ready_o is one-hot at the granted index.
  - When can_accept=0 or no request is valid, req_ready_o = 0.
- Transfer: a requester transfers when req_valid_i[k] && req_ready_o[k].
- On a transfer, next edge:
  - res_c_o <= mod_add result of requester k; res_id_o <= k; res_valid_o <= 1.
  - pointer <= (k+1) mod NB_REQ.
- Result drained with no new transfer (res_valid_o && res_ready_i): res_valid_o <= 0. res_c_o and res_id_o hold their last values.
- Stall (res_valid_o && !res_ready_i): res_c_o, res_id_o, res_valid_o and the pointer all hold. No grant is issued.
- Latency: one cycle from transfer to res_valid_o. Throughput: one result per cycle while res_ready_i=1.
- Simultaneous drain and transfer in the same cycle: the register is overwritten with the new result and res_valid_o stays 1.
- No request valid: the pointer holds.
- Requester rule: it may not change a/b or drop valid while valid=1 and ready=0. The arbiter does not depend on this rule; it re-evaluates every cycle.
- q_i changes only while res_valid_o=0 and no request is valid.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). An in-flight result is discarded.

Optional Feature:
MOD_ADD_ARB_STATS_EN
- Defined:
  - Adds port op_cnt_o, out, 16 bits: count of completed output handshakes (res_valid_o && res_ready_i).
  - Saturates at 16'hFFFF.
  - Reset value 0; asynchronous reset clears it.
- Not defined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
1. q=8380417; req0 a=5, b=7; res_ready_i=1 -> one cycle later res_valid_o=1, res_c_o=12, res_id_o=0. Next cycle res_valid_o=0.
2. q=8380417; req2 a=8380416, b=1 -> res_c_o=0, res_id_o=2. Then a=8380416, b=8380416 -> res_c_o=8380415.
3. All 4 requests held valid, res_ready_i=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles. res_valid_o stays 1 and res_id_o follows the same sequence one cycle later.
4. Result valid from req1, then res_ready_i=0 for 3 cycles with req0 and req3 valid:
   - during the stall: req_ready_o=0, res_c_o and res_id_o=1 hold;
   - first cycle after res_ready_i returns to 1: req3 is granted (pointer=2).
5. rst_ni pulled low mid-cycle during a stream:
   - res_valid_o and req_ready_o go to 0 immediately;
   - after release, with req1 and req0 valid, req0 is granted first.
6. With MOD_ADD_ARB_STATS_EN: 5 completed handshakes -> op_cnt_o=5. A stalled cycle does not increment op_cnt_o.
